task_dispatcher: RTL and testbench

TASK_DISPATCHER -- requirements
Module: task_dispatcher

---
 rtl/la_pkg.sv | 15 +
 rtl/cmd_capture.sv | 31 +++
 rtl/task_dispatcher.sv | 98 +++++++++
 tb/tb_task_dispatcher.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared command codes and dispatcher state encoding, used by the UART front end
// and the task blocks that hang off the dispatcher.
package la_pkg;

  localparam logic [7:0] CMD_ACQ  = 8'h61;  // 'a'
  localparam logic [7:0] CMD_TXD  = 8'h74;  // 't'
  localparam logic [7:0] CMD_BOTH = 8'h62;  // 'b'

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACQ  = 2'd1,
    ST_TXD  = 2'd2
  } state_t;

endpackage

// File: rtl/cmd_capture.sv
// Latches the UART byte while its valid level is high and emits a one-cycle strobe
// on the falling edge of that level, carrying the last byte seen.
module cmd_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_fresh,
  input  logic [7:0] i_data,
  output logic [7:0] o_cmd,
  output logic       o_strobe
);

  logic       r_fresh;
  logic [7:0] r_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fresh <= 1'b0;
      r_cmd   <= 8'h00;
    end else begin
      r_fresh <= i_fresh;
      if (i_fresh) begin
        r_cmd <= i_data;
      end
    end
  end

  // Strobe is combinational so the FSM acts on the very next edge after the level drops.
  assign o_strobe = r_fresh & ~i_fresh;
  assign o_cmd    = r_cmd;

endmodule

// File: rtl/task_dispatcher.sv
// Command-driven dispatcher: grants the acquisition and/or transmit task from a
// UART command and holds each grant until that task reports completion.
module task_dispatcher
  import la_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       grant_acq,
  output logic       grant_txd,
  input  logic       done_acq,
  input  logic       done_txd,
  input  logic       rx_data_fresh,
  input  logic [7:0] rx_data,
  output logic       led
);

  logic [7:0] w_cmd;
  logic       w_strobe;

  state_t r_state;
  logic   r_chain;
  logic   r_grant_acq;
  logic   r_grant_txd;
  logic   r_led;

  cmd_capture u_cmd_capture (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_fresh  (rx_data_fresh),
    .i_data   (rx_data),
    .o_cmd    (w_cmd),
    .o_strobe (w_strobe)
  );

  // Outputs are set alongside the state they describe, so they change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_chain     <= 1'b0;
      r_grant_acq <= 1'b0;
      r_grant_txd <= 1'b0;
      r_led       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            case (w_cmd)
              CMD_ACQ, CMD_BOTH: begin
                r_state     <= ST_ACQ;
                r_chain     <= (w_cmd == CMD_BOTH);
                r_grant_acq <= 1'b1;
                r_led       <= 1'b1;
              end
              CMD_TXD: begin
                r_state     <= ST_TXD;
                r_grant_txd <= 1'b1;
                r_led       <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_ACQ: begin
          if (done_acq) begin
            r_grant_acq <= 1'b0;
            r_chain     <= 1'b0;
            if (r_chain) begin
              r_state     <= ST_TXD;
              r_grant_txd <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_led   <= 1'b0;
            end
          end
        end
        ST_TXD: begin
          if (done_txd) begin
            r_state     <= ST_IDLE;
            r_grant_txd <= 1'b0;
            r_led       <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_chain     <= 1'b0;
          r_grant_acq <= 1'b0;
          r_grant_txd <= 1'b0;
          r_led       <= 1'b0;
        end
      endcase
    end
  end

  assign grant_acq = r_grant_acq;
  assign grant_txd = r_grant_txd;
  assign led       = r_led;

endmodule

// File: tb/tb_task_dispatcher.sv
// Randomized command/done traffic against a task-level reference model of the dispatcher.
module tb_task_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       grant_acq, grant_txd, led;
  logic       done_acq, done_txd;
  logic       rx_data_fresh;
  logic [7:0] rx_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which task is running, whether transmit follows, and UART history.
  int         m_task;   // 0 = none, 1 = acquisition, 2 = transmit
  bit         m_then_txd;
  bit         m_last_fresh;
  logic [7:0] m_last_byte;

  task_dispatcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .grant_acq     (grant_acq),
    .grant_txd     (grant_txd),
    .done_acq      (done_acq),
    .done_txd      (done_txd),
    .rx_data_fresh (rx_data_fresh),
    .rx_data       (rx_data),
    .led           (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_task       = 0;
    m_then_txd   = 1'b0;
    m_last_fresh = 1'b0;
    m_last_byte  = 8'h00;
  endfunction

  // One rising edge: a command is the byte seen just before the valid level dropped.
  function automatic void model_edge();
    bit cmd_ready;
    cmd_ready = m_last_fresh && !rx_data_fresh;
    if (m_task == 0) begin
      if (cmd_ready) begin
        if (m_last_byte == 8'h61)      begin m_task = 1; m_then_txd = 1'b0; end
        else if (m_last_byte == 8'h62) begin m_task = 1; m_then_txd = 1'b1; end
        else if (m_last_byte == 8'h74) m_task = 2;
      end
    end else if (m_task == 1) begin
      if (done_acq) m_task = m_then_txd ? 2 : 0;
    end else begin
      if (done_txd) m_task = 0;
    end
    if (rx_data_fresh) m_last_byte = rx_data;
    m_last_fresh = rx_data_fresh;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".grant_acq"}, {7'd0, grant_acq}, {7'd0, m_task == 1});
    chk({tag, ".grant_txd"}, {7'd0, grant_txd}, {7'd0, m_task == 2});
    chk({tag, ".led"},       {7'd0, led},       {7'd0, m_task != 0});
  endtask

  task automatic cycle(input string tag, input logic f, input logic [7:0] d,
                       input logic da, input logic dt);
    @(negedge clk);
    rx_data_fresh = f;
    rx_data       = d;
    done_acq      = da;
    done_txd      = dt;
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
    $display("cyc %s fresh=%0d data=%02h da=%0d dt=%0d -> acq=%0d txd=%0d led=%0d",
             tag, f, d, da, dt, grant_acq, grant_txd, led);
  endtask

  task automatic send_cmd(input string tag, input logic [7:0] cmd, input int len);
    for (int i = 0; i < len; i++)
      cycle(tag, 1'b1, (i == len - 1) ? cmd : 8'($urandom), 1'b0, 1'b0);
    cycle(tag, 1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rx_data_fresh = 1'b0;
    done_acq      = 1'b0;
    done_txd      = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1 check_outputs({tag, ".held"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] cmd_tab [6];
    logic [7:0] cmd;
    int         len, gap;
    cmd_tab[0] = 8'h61; cmd_tab[1] = 8'h74; cmd_tab[2] = 8'h62;
    cmd_tab[3] = 8'h00; cmd_tab[4] = 8'h7A; cmd_tab[5] = 8'h63;

    rst_n = 1'b0; rx_data_fresh = 1'b0; rx_data = 8'h00; done_acq = 1'b0; done_txd = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_outputs("reset");
    rst_n = 1'b1;
    cycle("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);

    // Chained command: acquisition then transmit.
    cycle("both", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("both", 1'b1, 8'd98, 1'b0, 1'b0);
    cycle("both", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("both.acq_up", {7'd0, grant_acq}, 8'd1);
    cycle("both", 1'b0, 8'h00, 1'b1, 1'b0);
    chk("both.handover", {6'd0, grant_acq, grant_txd}, 8'd1);
    cycle("both", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("both.done", {7'd0, led}, 8'd0);

    send_cmd("acq", 8'h61, 1);
    cycle("acq", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("acq", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("acq", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("acq.no_txd", {7'd0, grant_txd}, 8'd0);

    send_cmd("txd", 8'h74, 2);
    send_cmd("txd_busy", 8'h61, 1);
    cycle("txd", 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) cycle("txd_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    chk("txd.no_regrant", {7'd0, led}, 8'd0);

    send_cmd("bad00", 8'h00, 1);
    send_cmd("bad7a", 8'h7A, 3);
    chk("bad.led", {7'd0, led}, 8'd0);

    send_cmd("rst_mid", 8'h61, 1);
    do_reset("rst_mid");
    repeat (3) cycle("rst_after", 1'b0, 8'h61, 1'b0, 1'b0);

    for (int t = 0; t < 250; t++) begin
      cmd = (($urandom_range(0, 5)) == 0) ? 8'($urandom) : cmd_tab[$urandom_range(0, 5)];
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++)
        cycle("rnd", 1'b1, (i == len - 1) ? cmd : 8'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      gap = $urandom_range(1, 5);
      for (int i = 0; i < gap; i++)
        cycle("rnd", 1'b0, 8'($urandom),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) do_reset("rnd_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n && grant_acq && grant_txd) begin
      n_err++;
      $display("FAIL grant_overlap: got acq=1 txd=1 required at most one at %0t", $time);
    end
  end

endmodule
